// File: rtl/spi_slave_core.sv
// System-clock SPI slave: sck/cs_n/mosi are synchronised into clk, all four CPOL/CPHA modes,
// one-entry TX buffer with valid/ready, single-cycle RX strobe.
module spi_slave_core #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          LSB_FIRST   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_active,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe
);

    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    start;
    logic                    stop;

    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sck_d;
    logic                    cs_d;
    logic                    sck_s;
    logic                    cs_s;
    logic                    mosi_s;

    logic [FILL_W-1:0]       fill;
    logic                    armed_q;

    logic [1:0]              mode_q;
    logic                    preload_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [DATA_WIDTH-1:0]   rx_word;
    logic [DATA_WIDTH-1:0]   tx_buf;
    logic [DATA_WIDTH-1:0]   tx_shift;

    logic                    sck_rise;
    logic                    sck_fall;
    logic                    lead_edge;
    logic                    trail_edge;
    logic                    in_shift;
    logic                    sample_edge;
    logic                    drive_edge;
    logic                    word_done;
    logic                    boundary;
    logic                    cpha1_present;
    logic                    tx_load;
    logic                    tx_shift_en;

    // Input synchronisers plus one-cycle-delayed copies for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Arm only once a real (post-reset) cs_n high has reached the last stage, so a live frame is never joined
    always_ff @(posedge clk) begin
        if (rst) begin
            fill    <= '0;
            armed_q <= 1'b0;
        end else if (fill != FILL_W'(SYNC_STAGES)) begin
            fill <= fill + FILL_W'(1);
        end else if (cs_s) begin
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && cs_d && !cs_s) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s && !cs_d) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sck_rise    = sck_s && !sck_d;
    assign sck_fall    = !sck_s && sck_d;
    assign lead_edge   = mode_q[1] ? sck_fall : sck_rise;
    assign trail_edge  = mode_q[1] ? sck_rise : sck_fall;
    assign in_shift    = (state_q == SHIFT) && !stop;
    assign sample_edge = in_shift && (mode_q[0] ? trail_edge : lead_edge);
    assign drive_edge  = in_shift && (mode_q[0] ? lead_edge : trail_edge);

    assign word_done     = (bit_cnt == CNT_W'(DATA_WIDTH));
    assign boundary      = word_done || (bit_cnt == '0);
    // CPHA=1: the first drive edge of the frame only presents the word loaded at frame start
    assign cpha1_present = drive_edge && mode_q[0] && preload_q && boundary;
    assign tx_load       = start || (drive_edge && boundary && !cpha1_present);
    assign tx_shift_en   = drive_edge && !boundary;

    always_comb begin
        rx_word = rx_shift;
        if (LSB_FIRST) begin
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                rx_word[i] = rx_shift[DATA_WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= '0;
            preload_q    <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_buf       <= '0;
            tx_ready     <= 1'b1;
            tx_shift     <= '0;
            tx_underrun  <= 1'b0;
            frame_active <= 1'b0;
            miso_oe      <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_active <= (state_d == SHIFT);
            miso_oe      <= (state_d == SHIFT);

            if (start) begin
                mode_q    <= mode;
                preload_q <= 1'b1;
            end else if (cpha1_present) begin
                preload_q <= 1'b0;
            end

            if (sample_edge) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            end
            if (start || stop) begin
                bit_cnt <= '0;
            end else if (sample_edge) begin
                bit_cnt <= word_done ? CNT_W'(1) : bit_cnt + CNT_W'(1);
            end else if (word_done) begin
                bit_cnt <= '0;
            end
            if (word_done) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end

            // Handshake only when empty, so it never collides with a load of a full buffer
            if (tx_valid && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (tx_load) begin
                tx_ready <= 1'b1;
            end

            if (stop) begin
                tx_shift <= '0;
            end else if (tx_load) begin
                if (!tx_ready) begin
                    tx_shift <= tx_buf;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (tx_shift_en) begin
                if (LSB_FIRST) begin
                    tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // tx_shift is cleared whenever the frame is inactive, so miso is low with miso_oe
    assign miso = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_WIDTH-1];

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
System-clock SPI slave; successor to the sck-clocked slave.
- All of sck, cs_n and mosi are synchronised into clk; the core is fully synchronous to clk.
- Supports all four CPOL/CPHA modes, selectable bit order, and back-to-back multi-word frames while cs_n stays low.
- Host side uses a one-entry TX buffer with a valid/ready handshake and a single-cycle RX strobe. Sits between SPI pads and a register/FIFO layer.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (>=4).
- SYNC_STAGES, 2, synchroniser flops on sck/cs_n/mosi (>=2).
- LSB_FIRST, 0, 0 = MSB first on both mosi and miso; 1 = LSB first.

Ports:
- clk  in  1  system clock; must be >= 4x sck frequency.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  {CPOL,CPHA}; latched at frame start.
- tx_data  in  DATA_WIDTH  next word to transmit on miso.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX buffer empty; transfer occurs when tx_valid && tx_ready.
- rx_data  out  DATA_WIDTH  last complete word received on mosi.
- rx_valid  out  1  one-cycle strobe; rx_data is new.
- tx_underrun  out  1  one-cycle strobe; a word was started with an empty TX buffer.
- frame_active  out  1  high while in SHIFT state.
- sck  in  1  SPI clock (asynchronous).
- cs_n  in  1  chip select, active-low (asynchronous).
- mosi  in  1  master data in (asynchronous).
- miso  out  1  slave data out.
- miso_oe  out  1  pad output enable for miso.

Behaviour:

Reset values:
- rx_data=0, rx_valid=0, tx_underrun=0, frame_active=0, miso=0, miso_oe=0.
- TX buffer empty, so tx_ready=1 from the first cycle after reset.
- All synchroniser flops reset to 1 for cs_n, and to 0 for sck and mosi.

Synchronisation and edge detection:
- Edges are detected on the last synchroniser stage vs. a one-cycle-delayed copy.
- Leading edge = sck leaves the CPOL idle level. Trailing edge = sck returns to it.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Drive edge is the other one.

State machine: IDLE, SHIFT.
- IDLE -> SHIFT on synced cs_n falling.
  - Latch mode.
  - Clear the bit counter.
  - Load the TX shift register from the buffer.
  - frame_active=1 next cycle.
- SHIFT -> IDLE on synced cs_n rising.
  - Any partial RX word is discarded with no rx_valid.
  - The bit counter clears.
- Reset or a rise of cs_n mid-word aborts the frame.
- After rst, the block stays in IDLE until synced cs_n has been observed high at least one cycle. A frame already in progress is never joined mid-way.

RX path:
- On each sample edge, the synced mosi is shifted into the RX register and the bit counter increments.
- When the counter reaches DATA_WIDTH, on the next clk:
  - rx_data = assembled word (bit-reversed when LSB_FIRST=1);
  - rx_valid=1 for one cycle;
  - the counter wraps to 0 and the frame continues.
- No backpressure: rx_data is overwritten by the next word.

TX path and miso:
- miso is the shift register's MSB (or LSB when LSB_FIRST=1).
- CPHA=0:
  - The first bit is valid from the load at frame start.
  - Each drive (trailing) edge shifts by one.
  - The drive edge following the DATA_WIDTH-th sample reloads from the buffer instead of shifting.
- CPHA=1:
  - The first drive (leading) edge of a word loads/presents bit 0 without shifting.
  - Subsequent drive edges shift.
- Load with buffer full: buffer empties, so tx_ready rises next cycle.
- Load with buffer empty: shift register = 0 and tx_underrun pulses one cycle.
- No bypass: a tx_valid handshake in the same cycle as a load fills the buffer for the following word.
- miso_oe=1 exactly while frame_active=1. miso=0 whenever miso_oe=0.

Latency and mode handling:
- rx_valid rises SYNC_STAGES+2 clk cycles after the final sample edge at the pin.
- A change on mode mid-frame is ignored until the next frame.

Test Plan:
1. Mode 0, MSB-first, tx_data=0xA5 preloaded; master sends 0x3C in one 8-bit frame -> miso bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data=0x3C; tx_ready rises after the frame-start load.
2. Modes 1, 2 and 3, each with tx=0x81, master mosi=0x7E -> master captures 0x81 and rx_data=0x7E in every mode; sck idles at CPOL.
3. Mode 0, 3-word frame with tx buffer refilled 0x11/0x22 only after the first two loads and empty for word 3 -> master reads 0x11, 0x22, 0x00; tx_underrun pulses once at word 3; rx_valid pulses three times.
4. LSB_FIRST=1, tx=0x01, mosi stream bits 1,0,0,0,0,0,0,0 -> first miso bit =1; rx_data=0x01.
5. cs_n rises after 5 bits -> no rx_valid; next full frame of 0xC3 yields rx_data=0xC3 (counter restarted).
6. Assert rst mid-frame for 2 cycles, cs_n held low -> all outputs at reset values, miso_oe=0, no rx_valid. Further sck ignored until cs_n goes high; the next frame then works normally.
